// File: rtl/ghost_chase_ctrl.sv
// Per-ghost direction chooser: once per frame it picks the open, non-reversing move
// closest to a target that alternates scatter corner / Pac-Man on a frame-counted schedule.
module ghost_chase_ctrl #(
  parameter logic [9:0]  SCATTER_X      = 10'd380,
  parameter logic [9:0]  SCATTER_Y      = 10'd10,
  parameter logic [10:0] SCATTER_FRAMES = 11'd420,
  parameter logic [10:0] CHASE_FRAMES   = 11'd1200,
  parameter logic [2:0]  MAX_PHASES     = 3'd4,
  parameter logic [9:0]  STEP           = 10'd1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       lifeDown,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [7:0] dir,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'b00,
    MODE_CHASE   = 2'b01
  } mode_e;

  localparam logic [7:0] DIR_UP    = 8'h1A;
  localparam logic [7:0] DIR_LEFT  = 8'h04;
  localparam logic [7:0] DIR_DOWN  = 8'h16;
  localparam logic [7:0] DIR_RIGHT = 8'h07;

  // Index order doubles as tie priority; the reverse of index i is i ^ 2.
  localparam logic [1:0] IDX_UP    = 2'd0;
  localparam logic [1:0] IDX_LEFT  = 2'd1;
  localparam logic [1:0] IDX_DOWN  = 2'd2;
  localparam logic [1:0] IDX_RIGHT = 2'd3;

  mode_e       r_mode;
  logic [10:0] r_frame_cnt;
  logic [2:0]  r_phase_cnt;
  logic [1:0]  r_dir_idx;
  logic [7:0]  r_dir;

  logic [10:0] w_gx, w_gy, w_tx, w_ty, w_step;
  logic [10:0] w_cand_x [4];
  logic [10:0] w_cand_y [4];
  logic [10:0] w_cost   [4];
  logic [3:0]  w_open;
  logic [1:0]  w_rev_idx;
  logic        w_found;
  logic [1:0]  w_best_idx;
  logic [10:0] w_best_cost;
  logic [1:0]  w_next_idx;
  logic        w_scatter_end;
  logic        w_chase_end;
  logic        w_mode_change;

  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [7:0] idx_to_code(input logic [1:0] idx);
    logic [7:0] code;
    case (idx)
      IDX_UP:   code = DIR_UP;
      IDX_LEFT: code = DIR_LEFT;
      IDX_DOWN: code = DIR_DOWN;
      default:  code = DIR_RIGHT;
    endcase
    return code;
  endfunction

  assign w_gx   = {1'b0, ghostX};
  assign w_gy   = {1'b0, ghostY};
  assign w_step = {1'b0, STEP};
  assign w_tx   = (r_mode == MODE_CHASE) ? {1'b0, pacX} : {1'b0, SCATTER_X};
  assign w_ty   = (r_mode == MODE_CHASE) ? {1'b0, pacY} : {1'b0, SCATTER_Y};

  // 11-bit arithmetic keeps gX+STEP at the right screen edge from wrapping.
  always_comb begin
    w_cand_x[IDX_UP]    = w_gx;
    w_cand_y[IDX_UP]    = w_gy - w_step;
    w_cand_x[IDX_LEFT]  = w_gx - w_step;
    w_cand_y[IDX_LEFT]  = w_gy;
    w_cand_x[IDX_DOWN]  = w_gx;
    w_cand_y[IDX_DOWN]  = w_gy + w_step;
    w_cand_x[IDX_RIGHT] = w_gx + w_step;
    w_cand_y[IDX_RIGHT] = w_gy;
    for (int i = 0; i < 4; i++) begin
      w_cost[i] = abs_diff(w_cand_x[i], w_tx) + abs_diff(w_cand_y[i], w_ty);
    end
  end

  assign w_open[IDX_UP]    = (mapT == 5'd0);
  assign w_open[IDX_LEFT]  = (mapL == 5'd0);
  assign w_open[IDX_DOWN]  = (mapB == 5'd0);
  assign w_open[IDX_RIGHT] = (mapR == 5'd0);
  assign w_rev_idx         = r_dir_idx ^ 2'd2;

  // Strict less-than in priority order lets the earlier candidate win ties.
  always_comb begin
    w_found     = 1'b0;
    w_best_idx  = r_dir_idx;
    w_best_cost = '1;
    for (int i = 0; i < 4; i++) begin
      if (w_open[i] && (2'(i) != w_rev_idx) && (!w_found || (w_cost[i] < w_best_cost))) begin
        w_found     = 1'b1;
        w_best_idx  = 2'(i);
        w_best_cost = w_cost[i];
      end
    end
  end

  always_comb begin
    w_next_idx = r_dir_idx;
    if (w_found) begin
      w_next_idx = w_best_idx;
    end else if (w_open[w_rev_idx]) begin
      w_next_idx = w_rev_idx;
    end
  end

  assign w_scatter_end = (r_mode == MODE_SCATTER) && (r_frame_cnt == SCATTER_FRAMES - 11'd1);
  assign w_chase_end   = (r_mode == MODE_CHASE) && (r_phase_cnt < MAX_PHASES) &&
                         (r_frame_cnt == CHASE_FRAMES - 11'd1);
  assign w_mode_change = w_scatter_end || w_chase_end;

  always_ff @(posedge Clk) begin
    if (Reset || lifeDown) begin
      r_mode      <= MODE_SCATTER;
      r_frame_cnt <= 11'd0;
      r_phase_cnt <= 3'd0;
      r_dir_idx   <= IDX_LEFT;
      r_dir       <= DIR_LEFT;
    end else if (frame_tick) begin
      case (r_mode)
        MODE_SCATTER: begin
          if (w_scatter_end) begin
            r_mode      <= MODE_CHASE;
            r_frame_cnt <= 11'd0;
            r_phase_cnt <= r_phase_cnt + 3'd1;
          end else begin
            r_frame_cnt <= r_frame_cnt + 11'd1;
          end
        end
        MODE_CHASE: begin
          if (w_chase_end) begin
            r_mode      <= MODE_SCATTER;
            r_frame_cnt <= 11'd0;
          end else if (r_frame_cnt != 11'h7FF) begin
            r_frame_cnt <= r_frame_cnt + 11'd1;
          end
        end
        default: begin
          r_mode      <= MODE_SCATTER;
          r_frame_cnt <= 11'd0;
        end
      endcase
      // A mode flip forces a U-turn regardless of walls; the mover enforces them.
      if (w_mode_change) begin
        r_dir_idx <= w_rev_idx;
        r_dir     <= idx_to_code(w_rev_idx);
      end else begin
        r_dir_idx <= w_next_idx;
        r_dir     <= idx_to_code(w_next_idx);
      end
    end
  end

  assign dir  = r_dir;
  assign mode = r_mode;

endmodule

// File: tb/tb_ghost_chase_ctrl.sv
// Directed bench for ghost_chase_ctrl: vector table for the direction choice,
// hand sequences for reset, dead ends, the mode schedule and lifeDown.
module tb_ghost_chase_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       lifeDown = 1'b0;
  logic [9:0] ghostX = 10'd200, ghostY = 10'd200, pacX = 10'd0, pacY = 10'd0;
  logic [4:0] mapL = 5'd0, mapR = 5'd0, mapB = 5'd0, mapT = 5'd0;
  logic [7:0] dir;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0] gx, gy, px, py;
    logic [4:0] ml, mr, mb, mt;
    logic [7:0] exp_dir;
    logic [1:0] exp_mode;
  } vec_t;

  vec_t vecs [9];

  ghost_chase_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .lifeDown(lifeDown),
    .ghostX(ghostX), .ghostY(ghostY), .pacX(pacX), .pacY(pacY),
    .mapL(mapL), .mapR(mapR), .mapB(mapB), .mapT(mapT),
    .dir(dir), .mode(mode)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_walls(input logic [4:0] l, input logic [4:0] r,
                           input logic [4:0] b, input logic [4:0] t);
    mapL = l; mapR = r; mapB = b; mapT = t;
  endtask

  task automatic pulse_tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    if (n > 0) begin
      @(negedge Clk) frame_tick = 1'b1;
      repeat (n) @(negedge Clk);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] exp_dir;

    // Scatter target (380,10); the dir column chains from the previous row.
    vecs[0] = '{10'd200,  10'd200,  10'd0, 10'd0, 5'd0,  5'd0,  5'd0, 5'd0, 8'h1A, 2'b00};
    vecs[1] = '{10'd200,  10'd200,  10'd0, 10'd0, 5'd0,  5'd0,  5'd0, 5'd0, 8'h1A, 2'b00};
    vecs[2] = '{10'd200,  10'd200,  10'd0, 10'd0, 5'd0,  5'd0,  5'd0, 5'd1, 8'h07, 2'b00};
    vecs[3] = '{10'd400,  10'd10,   10'd0, 10'd0, 5'd0,  5'd0,  5'd0, 5'd0, 8'h1A, 2'b00};
    vecs[4] = '{10'd200,  10'd200,  10'd0, 10'd0, 5'd16, 5'd31, 5'd0, 5'd3, 8'h16, 2'b00};
    vecs[5] = '{10'd200,  10'd200,  10'd0, 10'd0, 5'd1,  5'd2,  5'd4, 5'd8, 8'h16, 2'b00};
    vecs[6] = '{10'd380,  10'd10,   10'd0, 10'd0, 5'd0,  5'd0,  5'd0, 5'd0, 8'h04, 2'b00};
    vecs[7] = '{10'd1,    10'd1,    10'd0, 10'd0, 5'd0,  5'd0,  5'd0, 5'd0, 8'h16, 2'b00};
    vecs[8] = '{10'd1022, 10'd1022, 10'd0, 10'd0, 5'd0,  5'd0,  5'd1, 5'd0, 8'h04, 2'b00};

    // Reset held with tick and lifeDown active must still win.
    Reset = 1'b1; frame_tick = 1'b1; lifeDown = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0; frame_tick = 1'b0; lifeDown = 1'b0;
    @(negedge Clk);
    check("reset_dir", dir, 8'h04);
    check("reset_mode", {6'd0, mode}, 8'h00);
    repeat (100) @(negedge Clk);
    check("idle_hold_dir", dir, 8'h04);
    check("idle_hold_mode", {6'd0, mode}, 8'h00);

    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      ghostX = vecs[i].gx; ghostY = vecs[i].gy; pacX = vecs[i].px; pacY = vecs[i].py;
      set_walls(vecs[i].ml, vecs[i].mr, vecs[i].mb, vecs[i].mt);
      frame_tick = 1'b1;
      @(negedge Clk) frame_tick = 1'b0;
      check($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
      check($sformatf("vec%0d_mode", i), {6'd0, mode}, {6'd0, vecs[i].exp_mode});
    end

    // Schedule from a clean reset; all walls blocked so dir only moves on U-turns.
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    set_walls(5'd31, 5'd31, 5'd31, 5'd31);
    run_ticks(419);
    check("scatter1_last_mode", {6'd0, mode}, 8'h00);
    check("scatter1_last_dir", dir, 8'h04);
    run_ticks(1);
    check("chase1_mode", {6'd0, mode}, 8'h01);
    check("chase1_reverse_dir", dir, 8'h07);

    // Chase toward Pac-Man below the ghost.
    ghostX = 10'd100; ghostY = 10'd100; pacX = 10'd100; pacY = 10'd300;
    set_walls(5'd1, 5'd1, 5'd0, 5'd1);
    pulse_tick();
    check("chase_only_down", dir, 8'h16);
    set_walls(5'd0, 5'd0, 5'd0, 5'd0);
    pulse_tick();
    check("chase_keep_down", dir, 8'h16);
    set_walls(5'd0, 5'd0, 5'd1, 5'd0);
    pulse_tick();
    check("chase_tie_left", dir, 8'h04);
    check("chase_tie_mode", {6'd0, mode}, 8'h01);

    set_walls(5'd31, 5'd31, 5'd31, 5'd31);
    run_ticks(1196);
    check("chase1_last_mode", {6'd0, mode}, 8'h01);
    run_ticks(1);
    check("scatter2_mode", {6'd0, mode}, 8'h00);
    check("scatter2_reverse_dir", dir, 8'h07);

    exp_dir = 8'h07;
    for (int p = 2; p <= 4; p++) begin
      run_ticks(419);
      check($sformatf("scatter%0d_last_mode", p), {6'd0, mode}, 8'h00);
      run_ticks(1);
      exp_dir = (exp_dir == 8'h04) ? 8'h07 : 8'h04;
      check($sformatf("chase%0d_mode", p), {6'd0, mode}, 8'h01);
      check($sformatf("chase%0d_dir", p), dir, exp_dir);
      if (p < 4) begin
        run_ticks(1199);
        check($sformatf("chase%0d_last_mode", p), {6'd0, mode}, 8'h01);
        run_ticks(1);
        exp_dir = (exp_dir == 8'h04) ? 8'h07 : 8'h04;
        check($sformatf("scatter%0d_mode", p + 1), {6'd0, mode}, 8'h00);
        check($sformatf("scatter%0d_dir", p + 1), dir, exp_dir);
      end
    end
    run_ticks(5000);
    check("perm_chase_mode", {6'd0, mode}, 8'h01);
    check("perm_chase_dir", dir, 8'h04);

    // Steer away from LEFT so the lifeDown restore is observable.
    set_walls(5'd31, 5'd31, 5'd31, 5'd0);
    pulse_tick();
    check("pre_death_dir", dir, 8'h1A);
    @(negedge Clk);
    lifeDown = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    lifeDown = 1'b0; frame_tick = 1'b0;
    check("death_mode", {6'd0, mode}, 8'h00);
    check("death_dir", dir, 8'h04);
    set_walls(5'd31, 5'd31, 5'd31, 5'd31);
    run_ticks(419);
    check("post_death_scatter_mode", {6'd0, mode}, 8'h00);
    check("post_death_scatter_dir", dir, 8'h04);
    run_ticks(1);
    check("post_death_chase_mode", {6'd0, mode}, 8'h01);
    check("post_death_chase_dir", dir, 8'h07);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
